// File: rtl/mux_arb_pkg.sv
// Shared constants for the mux select arbiter: FSM encoding, default
// parameters and the hold counter width.
package mux_arb_pkg;

   localparam logic [0:0] STATE_IDLE  = 1'b0;
   localparam logic [0:0] STATE_GRANT = 1'b1;

   localparam int SEL_W_DEF    = 3;
   localparam int MAX_HOLD_DEF = 4;
   localparam int HOLD_W       = 4;

endpackage : mux_arb_pkg

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Rotating-priority search: first requester at or after ptr, wrapping
// modulo N. Purely combinational.
module rr_pick #(
   parameter int SEL_W = 3
) (
   input  logic [2**SEL_W-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic                found,
   output logic [SEL_W-1:0]    idx
);

   logic [SEL_W-1:0] cand;

   // Walk ptr, ptr+1, ... with natural SEL_W-bit wrap; first hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < 2**SEL_W; i++) begin
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule : rr_pick

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of an 8:1 mux. Grants are
// registered, bounded to MAX_HOLD cycles, and always separated by at least
// one idle cycle so the mux output breaks before it makes.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no grant; gnt=0, sel keeps its last value, hold_cnt=0
//   GRANT | one requester owns the mux; gnt=1<<sel, hold_cnt counts
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int SEL_W    = SEL_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [2**SEL_W-1:0] req,
   output logic [SEL_W-1:0]    sel,
   output logic [2**SEL_W-1:0] gnt,
   output logic                busy,
   output logic [HOLD_W-1:0]   hold_cnt
);

   localparam int N = 2**SEL_W;
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

   logic [0:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;

   logic              pick_found;
   logic [SEL_W-1:0]  pick_idx;
   logic              release_grant;

   rr_pick #(
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Any one of these ends the current grant; other req bits are ignored.
   assign release_grant = !req[sel_q] || (hold_q == HOLD_LIMIT) || !en;

   // Next-state logic: grant from IDLE, release or extend from GRANT.
   // The pointer only moves on release, so a lone requester returns after
   // exactly one gap cycle.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      hold_d  = hold_q;
      ptr_d   = ptr_q;
      if (state_q == STATE_IDLE) begin
         if (en && pick_found) begin
            state_d          = STATE_GRANT;
            sel_d            = pick_idx;
            gnt_d            = '0;
            gnt_d[pick_idx]  = 1'b1;
            hold_d           = HOLD_W'(1);
         end
      end else begin
         if (release_grant) begin
            state_d = STATE_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
            ptr_d   = sel_q + SEL_W'(1);
         end else begin
            hold_d  = hold_q + HOLD_W'(1);
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= STATE_IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         hold_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
      end
   end

   assign sel      = sel_q;
   assign gnt      = gnt_q;
   assign busy     = (state_q == STATE_GRANT);
   assign hold_cnt = hold_q;

endmodule : mux_sel_arbiter

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (SEL_W=3, MAX_HOLD=4). Inputs change
// just after a rising edge; outputs are sampled 1 time unit after it.
module tb_mux_sel_arbiter;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic [3:0] hold_cnt;

   int checks = 0;
   int errors = 0;

   mux_sel_arbiter #(
      .SEL_W    (3),
      .MAX_HOLD (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .sel      (sel),
      .gnt      (gnt),
      .busy     (busy),
      .hold_cnt (hold_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output check; busy and one-hotness follow from the expected gnt.
   task automatic chk_out(input string tag, input logic [7:0] e_gnt,
                          input logic [2:0] e_sel, input logic [3:0] e_hold);
      chk({tag, ".gnt"},  32'(gnt), 32'(e_gnt));
      chk({tag, ".sel"},  32'(sel), 32'(e_sel));
      chk({tag, ".hold"}, 32'(hold_cnt), 32'(e_hold));
      chk({tag, ".busy"}, 32'(busy), 32'(e_gnt != 8'h00));
      chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
   endtask

   initial begin
      logic [2:0] w;
      rst = 1'b0;
      en  = 1'b1;
      req = 8'hFF;

      // Reset held for three edges with everyone requesting.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("rst%0d", i), 8'h00, 3'd0, 4'd0);
      end
      rst = 1'b1;

      // Full contention: 0..7 then 0 again, 4 cycles each, 1-cycle gaps.
      for (int r = 0; r < 9; r++) begin
         w = 3'(r % 8);
         for (int h = 1; h <= 4; h++) begin
            tick();
            chk_out($sformatf("ff_g%0d_h%0d", r, h), 8'(1) << w, w, 4'(h));
         end
         tick();
         chk_out($sformatf("ff_gap%0d", r), 8'h00, w, 4'd0);
      end

      // Lone requester 5 (ptr is 1): 4-cycle grant, gap with sel kept, repeat.
      req = 8'h20;
      for (int r = 0; r < 2; r++) begin
         for (int h = 1; h <= 4; h++) begin
            tick();
            chk_out($sformatf("lone%0d_h%0d", r, h), 8'h20, 3'd5, 4'(h));
         end
         tick();
         chk_out($sformatf("lone_gap%0d", r), 8'h00, 3'd5, 4'd0);
      end

      // Move ptr to 3: grant 2 (search from 6 wraps), drop it at once.
      req = 8'h04;
      tick();
      chk_out("pre2", 8'h04, 3'd2, 4'd1);
      req = 8'h00;
      tick();
      chk_out("pre2_rel", 8'h00, 3'd2, 4'd0);

      // Early drop and wrap: 3 wins, dropped after 2 cycles, then 0 wins.
      req = 8'h09;
      tick();
      chk_out("drop_g1", 8'h08, 3'd3, 4'd1);
      tick();
      chk_out("drop_g2", 8'h08, 3'd3, 4'd2);
      req = 8'h01;
      tick();
      chk_out("drop_rel", 8'h00, 3'd3, 4'd0);
      tick();
      chk_out("wrap_g0", 8'h01, 3'd0, 4'd1);
      tick();
      chk_out("wrap_g0h2", 8'h01, 3'd0, 4'd2);

      // Enable low mid-grant releases; nothing granted while disabled.
      en  = 1'b0;
      req = 8'hFF;
      tick();
      chk_out("en_rel", 8'h00, 3'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("en_off%0d", i), 8'h00, 3'd0, 4'd0);
      end
      en = 1'b1;
      tick();
      chk_out("en_on", 8'h02, 3'd1, 4'd1);

      // Reset mid-grant of requester 6 at hold_cnt 2.
      req = 8'h40;
      tick();
      chk_out("pre6_rel", 8'h00, 3'd1, 4'd0);
      tick();
      chk_out("g6_h1", 8'h40, 3'd6, 4'd1);
      tick();
      chk_out("g6_h2", 8'h40, 3'd6, 4'd2);
      rst = 1'b0;
      req = 8'hFF;
      tick();
      chk_out("rst_mid", 8'h00, 3'd0, 4'd0);
      rst = 1'b1;
      tick();
      chk_out("post_rst", 8'h01, 3'd0, 4'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mux_sel_arbiter
